// File: rtl/game_pkg.sv
// Shared types and helpers for the target game: FSM states, target count and index helpers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    SHOW,
    GAP,
    DONE
  } state_t;

  localparam int         NUM_TARGETS = 6;
  localparam logic [2:0] MAX_IDX     = 3'd5;
  localparam logic [1:0] MAX_RETRIES = 2'd3;

  // Out-of-range upstream values (6, 7) fold onto the last target.
  function automatic logic [2:0] clamp_idx(input logic [2:0] r);
    return (r > MAX_IDX) ? MAX_IDX : r;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == MAX_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [NUM_TARGETS-1:0] onehot(input logic [2:0] i);
    return NUM_TARGETS'(1) << i;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; o_expire is high for the single cycle the count sits at 1.
module cycle_timer #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loading value N gives exactly N cycles before and including the expire cycle.
  assign o_expire = (cnt_q == W'(1));

endmodule

// File: rtl/target_scheduler.sv
// Timed-round target game sequencer. Define NO_REPEAT_EN to re-request the random stage
// when a round would light the same target as the previous one.
module target_scheduler
  import game_pkg::*;
#(
  parameter int ROUNDS      = 16,
  parameter int SHOW_CYCLES = 1000,
  parameter int GAP_CYCLES  = 100,
  parameter int SCORE_W     = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_game_start,
  input  logic [NUM_TARGETS-1:0]         i_btn,
  input  logic [2:0]                     i_rand,
  output logic                           o_rand_start,
  output logic [NUM_TARGETS-1:0]         o_target,
  output logic [SCORE_W-1:0]             o_score,
  output logic [$clog2(ROUNDS+1)-1:0]    o_round,
  output logic                           o_hit,
  output logic                           o_miss,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int RND_W   = $clog2(ROUNDS + 1);
  localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SHOW_LD    = TMR_W'(SHOW_CYCLES);
  localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP_CYCLES);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS);

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
`ifdef NO_REPEAT_EN
  logic                 prev_valid_q, prev_valid_d;
  logic [1:0]           retry_q, retry_d;
`endif

  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_value;
  logic                   tmr_expire;
  logic [2:0]             rand_idx;
  logic [NUM_TARGETS-1:0] lit;
  logic                   go_show;
  logic                   btn_hit;
  logic [RND_W-1:0]       round_inc;

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (tmr_load),
    .i_value  (tmr_value),
    .o_expire (tmr_expire)
  );

  assign rand_idx  = clamp_idx(i_rand);
  assign lit       = onehot(idx_q);
  assign btn_hit   = (i_btn == lit);
  assign round_inc = round_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    score_d   = score_q;
    round_d   = round_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    go_show   = 1'b1;
`ifdef NO_REPEAT_EN
    prev_valid_d = prev_valid_q;
    retry_d      = retry_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (i_game_start) begin
          score_d = '0;
          round_d = '0;
          state_d = REQ;
`ifdef NO_REPEAT_EN
          prev_valid_d = 1'b0;
          retry_d      = '0;
`endif
        end
      end

      REQ: begin
        state_d = LOAD;
      end

      LOAD: begin
        idx_d = rand_idx;
`ifdef NO_REPEAT_EN
        if (prev_valid_q && (rand_idx == idx_q)) begin
          if (retry_q < MAX_RETRIES) begin
            idx_d   = idx_q;
            retry_d = retry_q + 1'b1;
            go_show = 1'b0;
            state_d = REQ;
          end else begin
            idx_d = next_idx(rand_idx);
          end
        end
        if (go_show) begin
          prev_valid_d = 1'b1;
          retry_d      = '0;
        end
`endif
        if (go_show) begin
          tmr_load  = 1'b1;
          tmr_value = SHOW_LD;
          state_d   = SHOW;
        end
      end

      SHOW: begin
        // A press on the expiry cycle is judged as a press, not a timeout.
        if ((i_btn != '0) || tmr_expire) begin
          hit_d     = btn_hit;
          miss_d    = !btn_hit;
          round_d   = round_inc;
          tmr_load  = 1'b1;
          tmr_value = GAP_LD;
          if (btn_hit && (score_q != '1)) begin
            score_d = score_q + 1'b1;
          end
          state_d = (round_inc == LAST_ROUND) ? DONE : GAP;
        end
      end

      GAP: begin
        if (tmr_expire) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      score_q      <= '0;
      round_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
`ifdef NO_REPEAT_EN
      prev_valid_q <= 1'b0;
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      score_q      <= score_d;
      round_q      <= round_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
`ifdef NO_REPEAT_EN
      prev_valid_q <= prev_valid_d;
      retry_q      <= retry_d;
`endif
    end
  end

  assign o_rand_start = (state_q == REQ);
  assign o_target     = (state_q == SHOW) ? lit : '0;
  assign o_score      = score_q;
  assign o_round      = round_q;
  assign o_hit        = hit_q;
  assign o_miss       = miss_q;
  assign o_busy       = (state_q != IDLE) && (state_q != DONE);
  assign o_done       = (state_q == DONE);

endmodule
